// File: rtl/cve2_xif_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cve2_xif_result_arbiter
// Description : Merges X_NUM_CH CORE-V XIF coprocessor result channels into
//               the single CPU-side result channel. Each channel has a
//               DEPTH-entry FIFO. A round-robin arbiter drains the FIFOs into
//               one registered output stage with a valid/ready handshake.
//
// Optional    : `define CVE2_XIF_RESULT_ARB_EXC_PRIO_EN makes channels whose
//               head entry carries exc=1 or err=1 win over normal entries.
//               Round-robin order still applies among those channels.
//
// Ports       : clk_i                  clock
//               rst_i                  synchronous active-high reset
//               coproc_result_valid_i  per-channel result valid
//               coproc_result_ready_o  per-channel result ready (= !full)
//               coproc_result_i        per-channel packed results, channel k
//                                      at [k*RES_W +: RES_W]
//               cpu_result_valid_o     merged result valid
//               cpu_result_ready_i     core accepts result
//               cpu_result_o           merged packed result
//               cpu_result_src_o       channel index of presented result
//
// Result packing (MSB first): id, hartid, data, rd, we, ecsdata, ecswe,
//               exc, exccode, err, dbg
//
// Revision    : 1.0  initial release
// ============================================================================
module cve2_xif_result_arbiter #(
    parameter  int X_NUM_CH       = 2,
    parameter  int DEPTH          = 2,
    parameter  int X_ID_WIDTH     = 4,
    parameter  int X_HARTID_WIDTH = 1,
    parameter  int X_RFW_WIDTH    = 32,
    parameter  int X_DUALWRITE    = 0,
    localparam int RES_W          = X_ID_WIDTH + X_HARTID_WIDTH + X_RFW_WIDTH
                                    + 5 + (X_DUALWRITE + 1) + 6 + 3 + 1 + 6 + 1 + 1,
    localparam int SRC_W          = (X_NUM_CH > 1) ? $clog2(X_NUM_CH) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [X_NUM_CH-1:0]       coproc_result_valid_i,
    output logic [X_NUM_CH-1:0]       coproc_result_ready_o,
    input  logic [X_NUM_CH*RES_W-1:0] coproc_result_i,
    output logic                      cpu_result_valid_o,
    input  logic                      cpu_result_ready_i,
    output logic [RES_W-1:0]          cpu_result_o,
    output logic [SRC_W-1:0]          cpu_result_src_o
);

    localparam int               AW    = $clog2(DEPTH);
    localparam logic [SRC_W:0]   C_NUM = (SRC_W + 1)'(X_NUM_CH);
    localparam logic [SRC_W-1:0] C_LAST = SRC_W'(X_NUM_CH - 1);

    // ------------------------------------------------------------------
    // Per-channel FIFO state
    // ------------------------------------------------------------------
    logic [X_NUM_CH-1:0] w_empty;
    logic [X_NUM_CH-1:0] w_full;
    logic [X_NUM_CH-1:0] w_pop;
    logic [RES_W-1:0]    w_head [X_NUM_CH];

    // ------------------------------------------------------------------
    // Arbiter / output stage signals
    // ------------------------------------------------------------------
    logic [X_NUM_CH-1:0]   w_req;
    logic [2*X_NUM_CH-1:0] w_req2;
    logic [X_NUM_CH-1:0]   w_rot;
    logic [SRC_W-1:0]      w_off;
    logic [SRC_W:0]        w_sum;
    logic [SRC_W-1:0]      w_grant;
    logic [SRC_W-1:0]      w_rr_next;
    logic                  w_found;
    logic                  w_load_en;
    logic [RES_W-1:0]      w_sel;

    logic                  r_valid;
    logic [RES_W-1:0]      r_data;
    logic [SRC_W-1:0]      r_src;
    logic [SRC_W-1:0]      r_rr_ptr;

    for (genvar k = 0; k < X_NUM_CH; k++) begin : g_ch
        logic [RES_W-1:0] r_mem [DEPTH];
        logic [AW:0]      r_wptr;
        logic [AW:0]      r_rptr;
        logic             w_push;

        // Extra pointer MSB distinguishes full from empty when the low bits match.
        assign w_empty[k] = (r_wptr == r_rptr);
        assign w_full[k]  = (r_wptr[AW] != r_rptr[AW]) &&
                            (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

        // Ready depends only on stored state (and reset), never on the
        // CPU-side ready, so a full FIFO stays not-ready while it is popped.
        assign coproc_result_ready_o[k] = ~w_full[k] & ~rst_i;
        assign w_push  = coproc_result_valid_i[k] & coproc_result_ready_o[k];
        assign w_pop[k] = w_load_en & w_found & (w_grant == SRC_W'(k));
        assign w_head[k] = r_mem[r_rptr[AW-1:0]];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop[k]) begin
                    r_rptr <= r_rptr + 1'b1;
                end
            end
        end

        // Storage needs no reset: entries are only read once pointers say valid.
        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= coproc_result_i[k*RES_W +: RES_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request vector
    // ------------------------------------------------------------------
`ifdef CVE2_XIF_RESULT_ARB_EXC_PRIO_EN
    localparam int C_EXC_BIT = 8;
    localparam int C_ERR_BIT = 1;
    logic [X_NUM_CH-1:0] w_prio;

    for (genvar k = 0; k < X_NUM_CH; k++) begin : g_prio
        assign w_prio[k] = ~w_empty[k] &
                           (w_head[k][C_EXC_BIT] | w_head[k][C_ERR_BIT]);
    end

    // Exceptional heads mask out normal ones; rotation below keeps fairness.
    assign w_req = (|w_prio) ? w_prio : ~w_empty;
`else
    assign w_req = ~w_empty;
`endif

    // ------------------------------------------------------------------
    // Round-robin grant: rotate requests so rr_ptr lands at bit 0, find the
    // lowest set bit, then rotate the offset back modulo X_NUM_CH.
    // ------------------------------------------------------------------
    assign w_req2  = {w_req, w_req};
    assign w_rot   = X_NUM_CH'(w_req2 >> r_rr_ptr);
    assign w_found = |w_req;

    always_comb begin
        w_off = '0;
        for (int i = X_NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SRC_W'(i);
            end
        end
    end

    assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_grant   = (w_sum >= C_NUM) ? SRC_W'(w_sum - C_NUM) : SRC_W'(w_sum);
    assign w_rr_next = (w_grant == C_LAST) ? '0 : (w_grant + 1'b1);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < X_NUM_CH; i++) begin
            if (w_grant == SRC_W'(i)) begin
                w_sel = w_head[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------
    assign w_load_en = ~r_valid | cpu_result_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_src    <= '0;
            r_rr_ptr <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_valid  <= 1'b1;
                r_data   <= w_sel;
                r_src    <= w_grant;
                r_rr_ptr <= w_rr_next;
            end else begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign cpu_result_valid_o = r_valid;
    assign cpu_result_o       = r_data;
    // With a single channel the grant is constantly zero, so this is tied 0.
    assign cpu_result_src_o   = r_src;

endmodule
`default_nettype wire
